// File: rtl/bitty_seq_pkg.sv
// bitty_seq_pkg: shared state encoding and instruction constants for the bitty sequencer
// Contents: state_e FSM states, halt opcode, branch format tag, branch condition codes.
package bitty_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT} state_e;
  localparam logic [15:0] HALT_OPCODE = 16'hFFFF;
  localparam logic [1:0] FMT_BRANCH = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO = 2'b01;
  localparam logic [1:0] COND_NZERO = 2'b10;
  localparam logic [1:0] COND_NEVER = 2'b11;
endpackage

// File: rtl/bitty_seq_decode.sv
// bitty_seq_decode: combinational classifier for halt / branch instructions
// Inputs: instr (instruction register), last_result (last core result).
// Outputs: is_halt, is_branch, branch_taken, branch_target (instr[15:4] fitted to PC_W).
module bitty_seq_decode
  import bitty_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [15:0]     instr,
  input  logic [15:0]     last_result,
  output logic            is_halt,
  output logic            is_branch,
  output logic            branch_taken,
  output logic [PC_W-1:0] branch_target
);
  logic z;
  assign z = last_result == 16'h0000;
  assign is_halt = instr == HALT_OPCODE;
  assign is_branch = !is_halt && instr[1:0] == FMT_BRANCH;
  assign branch_taken = instr[3:2] == COND_ALWAYS || (instr[3:2] == COND_ZERO && z) ||
                        (instr[3:2] == COND_NZERO && !z);
  if (PC_W <= 12) begin : g_trunc
    assign branch_target = instr[PC_W+3:4];
  end else begin : g_ext
    assign branch_target = {{(PC_W-12){1'b0}}, instr[15:4]};
  end
endmodule

// File: rtl/bitty_seq.sv
// bitty_seq: program sequencer that fetches, dispatches to bitty, and executes branch/halt itself
// Ports: clk, reset (async active-low), start/stop control; imem_req/addr/valid/rdata fetch
// handshake; core_instr/core_run/core_done/core_result core interface; pc, busy, halted,
// instr_count status. Optional BITTY_SEQ_WDOG_EN adds wdog_err and a WAIT-state watchdog.
module bitty_seq
  import bitty_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int START_ADDR = 0,
  parameter int WDOG_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     core_instr,
  output logic            core_run,
  input  logic            core_done,
  input  logic [15:0]     core_result,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     instr_count
`ifdef BITTY_SEQ_WDOG_EN
  ,
  output logic            wdog_err
`endif
);
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt;
  logic [15:0] ir_q, ir_d, ci_q, ci_d, cnt_q, cnt_d, last_q, last_d;
  logic stop_q, stop_d, pend, retire, is_halt, is_branch, taken;
`ifdef BITTY_SEQ_WDOG_EN
  logic [15:0] wd_q, wd_d;
  logic err_q, err_d;
  assign wdog_err = err_q;
`endif
  bitty_seq_decode #(.PC_W(PC_W)) u_dec (
    .instr(ir_q), .last_result(last_q), .is_halt(is_halt), .is_branch(is_branch),
    .branch_taken(taken), .branch_target(tgt)
  );
  assign pc_inc = pc_q + PC_W'(1);
  assign imem_req = state_q == S_FETCH;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign core_instr = ci_q;
  assign core_run = state_q == S_EXEC;
  assign halted = state_q == S_HALT;
  assign busy = state_q != S_IDLE && state_q != S_HALT;
  assign instr_count = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    ci_d = ci_q;
    last_d = last_q;
    cnt_d = cnt_q;
    retire = 1'b0;
    pend = stop_q | stop;
    stop_d = busy ? pend : stop_q;
`ifdef BITTY_SEQ_WDOG_EN
    wd_d = '0;
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: if (start) begin
        state_d = S_FETCH;
        pc_d = START;
        cnt_d = '0;
        stop_d = 1'b0;
`ifdef BITTY_SEQ_WDOG_EN
        err_d = 1'b0;
`endif
      end
      S_FETCH: if (imem_valid) begin
        ir_d = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: if (is_halt) begin
        state_d = S_HALT;
        retire = 1'b1;
      end else if (is_branch) begin
        pc_d = taken ? tgt : pc_inc;
        retire = 1'b1;
        state_d = pend ? S_IDLE : S_FETCH;
      end else begin
        ci_d = ir_q;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: if (core_done) begin
        last_d = core_result;
        pc_d = pc_inc;
        retire = 1'b1;
        state_d = pend ? S_IDLE : S_FETCH;
      end
`ifdef BITTY_SEQ_WDOG_EN
      else if (wd_q == 16'(WDOG_CYCLES - 1)) begin
        state_d = S_HALT;
        err_d = 1'b1;
      end else wd_d = wd_q + 16'd1;
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) stop_d = 1'b0;
    if (retire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q <= START;
      ir_q <= '0;
      ci_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      stop_q <= 1'b0;
`ifdef BITTY_SEQ_WDOG_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ci_q <= ci_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      stop_q <= stop_d;
`ifdef BITTY_SEQ_WDOG_EN
      wd_q <= wd_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_bitty_seq.sv
// tb_bitty_seq: self-checking bench with memory/core models and an instruction-level reference
module tb_bitty_seq;
  logic clk = 0, reset = 0, start = 0, stop = 0, imem_valid = 0, core_done = 0;
  logic [15:0] imem_rdata = 0, core_result = 0, core_instr, instr_count, cins = 0, fres = 0;
  logic imem_req, core_run, busy, halted;
  logic [7:0] imem_addr, pc;
`ifdef BITTY_SEQ_WDOG_EN
  logic wdog_err;
`endif
  int cmp = 0, bad = 0, mlat = 0, clat = 3, runs = 0, cwait = 0;
  bit cpend = 0, cen = 1, fen = 0;
  logic [15:0] mem [256];
  typedef struct {logic [15:0] ins; logic [15:0] res; logic [7:0] epc; int ecnt; int eruns;} vec_t;
  vec_t tv [12];
  always #5 clk = ~clk;
  bitty_seq dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .core_instr(core_instr), .core_run(core_run), .core_done(core_done),
    .core_result(core_result), .pc(pc), .busy(busy), .halted(halted),
    .instr_count(instr_count)
`ifdef BITTY_SEQ_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );
  function automatic logic [15:0] core_fn(input logic [15:0] i);
    return i[6] ? 16'h0000 : (i ^ 16'h00A5) | 16'h0100;
  endfunction
  function automatic void model(output logic [7:0] p, output int c, output int r);
    logic [15:0] last, i;
    bit tk;
    last = 0; p = 0; c = 0; r = 0;
    for (int s = 0; s < 2000; s++) begin
      i = mem[p];
      c++;
      if (i == 16'hFFFF) break;
      if (i[1:0] == 2'b10) begin
        tk = (i[3:2] == 2'b00) || (i[3:2] == 2'b01 && last == 0) || (i[3:2] == 2'b10 && last != 0);
        p = tk ? i[11:4] : p + 8'd1;
      end else begin
        last = core_fn(i);
        r++;
        p = p + 8'd1;
      end
    end
  endfunction
  initial begin
    int mw;
    mw = 0;
    forever begin
      @(negedge clk);
      if (!imem_req) begin
        imem_valid = 0;
        mw = $urandom_range(mlat, 0);
      end else if (mw == 0) begin
        imem_valid = 1;
        imem_rdata = mem[imem_addr];
      end else begin
        mw--;
        imem_valid = 0;
      end
      core_done = 0;
      if (!reset) cpend = 0;
      else if (cpend) begin
        if (cwait == 0) begin
          core_done = 1;
          core_result = fen ? fres : core_fn(cins);
          cpend = 0;
        end else cwait--;
      end
      if (core_run) begin
        runs++;
        cins = core_instr;
        cpend = cen;
        cwait = clat - 1;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic rst();
    @(negedge clk);
    reset = 0; start = 0; stop = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask
  task automatic go();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic wait_end(input string n);
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk({n, "_timeout"}, 1, 0);
  endtask
  task automatic wait_run(input string n);
    int k;
    k = 0;
    while (!core_run && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!core_run) chk({n, "_run_timeout"}, 0, 1);
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask
  initial begin
    int n, ecnt, eruns;
    logic [7:0] epc;
    bit seen;
    tv[0] = '{16'h0202, 16'h0000, 8'h20, 3, 1};
    tv[1] = '{16'h0306, 16'h0000, 8'h30, 3, 1};
    tv[2] = '{16'h0306, 16'h0005, 8'h02, 3, 1};
    tv[3] = '{16'h030A, 16'h0005, 8'h30, 3, 1};
    tv[4] = '{16'h030A, 16'h0000, 8'h02, 3, 1};
    tv[5] = '{16'h030E, 16'h0000, 8'h02, 3, 1};
    tv[6] = '{16'hF402, 16'h0005, 8'h40, 3, 1};
    tv[7] = '{16'h1234, 16'h0005, 8'h02, 3, 2};
    tv[8] = '{16'h0FF2, 16'h0000, 8'hFF, 3, 1};
    tv[9] = '{16'hFFFF, 16'h0000, 8'h01, 2, 1};
    tv[10] = '{16'hFFFE, 16'h0000, 8'h02, 3, 1};
    tv[11] = '{16'hFFFD, 16'h0007, 8'h02, 3, 2};
    fill(16'hFFFF);
    rst();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_core_instr", core_instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_pc", pc, 0);
    mem[0] = 16'h0011; mem[1] = 16'h0021;
    mlat = 0; clat = 3; runs = 0;
    go();
    n = 1;
    while (!core_run && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("alu_latency", n, 3);
    wait_end("alu");
    chk("alu_runs", runs, 2);
    chk("alu_count", instr_count, 3);
    chk("alu_halted", halted, 1);
    chk("alu_pc", pc, 2);
    fill(16'hFFFF);
    mem[0] = 16'h0202; mem[8'h20] = 16'h0001;
    runs = 0;
    go();
    @(negedge clk);
    @(negedge clk);
    chk("br_lat_req", imem_req, 1);
    chk("br_lat_addr", imem_addr, 8'h20);
    chk("br_lat_runs", runs, 0);
    wait_end("br");
    for (int i = 0; i < 12; i++) begin
      rst();
      fill(16'hFFFF);
      mem[0] = 16'h0001; mem[1] = tv[i].ins;
      fen = 1; fres = tv[i].res; mlat = i % 3; clat = 1 + i % 3; runs = 0;
      go();
      wait_end($sformatf("tv%0d", i));
      chk($sformatf("tv%0d_pc", i), pc, tv[i].epc);
      chk($sformatf("tv%0d_count", i), instr_count, tv[i].ecnt);
      chk($sformatf("tv%0d_runs", i), runs, tv[i].eruns);
      chk($sformatf("tv%0d_halted", i), halted, 1);
    end
    fen = 0;
    rst();
    fill(16'h0001);
    clat = 5; mlat = 1; runs = 0;
    go();
    wait_run("stop");
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    wait_end("stop");
    chk("stop_pc", pc, 1);
    chk("stop_count", instr_count, 1);
    chk("stop_halted", halted, 0);
    chk("stop_runs", runs, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= imem_req;
    end
    chk("stop_no_req", seen, 0);
    fill(16'hFFFF);
    mem[0] = 16'h0001;
    fen = 1; fres = 16'h0005; clat = 4; mlat = 0;
    go();
    wait_run("rstw");
    @(negedge clk);
    reset = 0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_run", core_run, 0);
    chk("rstw_instr", core_instr, 0);
    chk("rstw_pc", pc, 0);
    chk("rstw_req", imem_req, 0);
    @(negedge clk);
    reset = 1;
    runs = 0;
    repeat (6) @(negedge clk);
    chk("rstw_no_run", runs, 0);
    chk("rstw_idle", busy | halted, 0);
    fill(16'hFFFF);
    mem[0] = 16'h0FE6; mem[8'hFE] = 16'h0001; mem[8'hFF] = 16'h0001;
    runs = 0;
    go();
    wait_end("wrap");
    chk("wrap_pc", pc, 1);
    chk("wrap_count", instr_count, 5);
    chk("wrap_runs", runs, 2);
    fill(16'hFFFF);
    mem[0] = 16'h0001; mem[1] = 16'h0001;
    @(negedge clk);
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    wait_end("ss");
    chk("ss_halted", halted, 1);
    chk("ss_count", instr_count, 3);
    chk("ss_pc", pc, 2);
    fen = 0;
    for (int k = 0; k < 8; k++) begin
      rst();
      fill(16'hFFFF);
      for (int a = 0; a < 23; a++) begin
        int r;
        logic [15:0] w;
        r = $urandom_range(9, 0);
        if (r == 0) w = 16'hFFFF;
        else if (r < 5) w = {4'($urandom), 8'($urandom_range(23, a + 1)), 2'($urandom), 2'b10};
        else begin
          w = 16'($urandom);
          if (w[1:0] == 2'b10) w[1:0] = 2'b11;
          if (w == 16'hFFFF) w = 16'h0F0F;
        end
        mem[a] = w;
      end
      mlat = $urandom_range(3, 0); clat = $urandom_range(4, 1); runs = 0;
      model(epc, ecnt, eruns);
      go();
      wait_end($sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d_pc", k), pc, epc);
      chk($sformatf("rnd%0d_count", k), instr_count, ecnt);
      chk($sformatf("rnd%0d_runs", k), runs, eruns);
      chk($sformatf("rnd%0d_halted", k), halted, 1);
    end
`ifdef BITTY_SEQ_WDOG_EN
    rst();
    fill(16'hFFFF);
    mem[0] = 16'h0001;
    cen = 0; mlat = 0;
    go();
    wait_run("wd");
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wd_latency", n, 65);
    chk("wd_err", wdog_err, 1);
    chk("wd_count", instr_count, 0);
    cen = 1;
    go();
    chk("wd_clear", wdog_err, 0);
    wait_end("wd2");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
